// File: rtl/alu_req_arbiter_pkg.sv
// Shared types for the ALU request arbiter: ALU opcodes, arbiter FSM states and bus widths.
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NO_OP = 3'b000,
    OP_ADD   = 3'b001,
    OP_AND   = 3'b010,
    OP_XOR   = 3'b011,
    OP_MUL   = 3'b100,
    OP_RST   = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // True for opcodes that must actually be sent to the ALU.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_AND, OP_XOR, OP_MUL, OP_RST: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester command/response bus plus ALU port group seen by the arbiter.
interface alu_req_arbiter_if import alu_pkg::*; #(parameter int N_REQ = 4);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [OP_W*N_REQ-1:0]   req_op;
  logic [DATA_W*N_REQ-1:0] req_a;
  logic [DATA_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]        rsp_valid;
  logic [RES_W-1:0]        rsp_result;
  logic                    rsp_error;
  logic                    alu_start;
  logic [OP_W-1:0]         alu_op;
  logic [DATA_W-1:0]       alu_a;
  logic [DATA_W-1:0]       alu_b;
  logic                    alu_done;
  logic [RES_W-1:0]        alu_result;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_done, alu_result,
    output req_ready, rsp_valid, rsp_result, rsp_error,
           alu_start, alu_op, alu_a, alu_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_done, alu_result,
    input  req_ready, rsp_valid, rsp_result, rsp_error,
           alu_start, alu_op, alu_a, alu_b
  );

endinterface

// File: rtl/alu_req_arbiter_rr.sv
// Combinational round-robin pick: first active request at or above ptr_i, wrapping at N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_any_o
);

  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;

  logic [CW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + CW'(k);
      if (cand >= CW'(N)) begin
        cand = cand - CW'(N);
      end
      if (!gnt_any_o && req_i[cand[IW-1:0]]) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = cand[IW-1:0];
      end
    end
    if (gnt_any_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one 8x8->16 ALU among N_REQ requesters: round-robin accept, one op in flight,
// local completion of no_op/illegal ops, and a timeout for a hung ALU.
module alu_req_arbiter import alu_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_req_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [OP_W-1:0]    sel_op;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign sel_op = bus.req_op[OP_W*int'(gnt_idx) +: OP_W];
  assign sel_a  = bus.req_a[DATA_W*int'(gnt_idx) +: DATA_W];
  assign sel_b  = bus.req_b[DATA_W*int'(gnt_idx) +: DATA_W];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          op_d     = sel_op;
          a_d      = sel_a;
          b_d      = sel_b;
          gidx_d   = gnt_idx;
          cnt_d    = '0;
          result_d = '0;
          err_d    = 1'b0;
          ptr_d    = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
          // no_op and the two unassigned codes never touch the ALU
          if (is_alu_op(sel_op)) begin
            state_d = BUSY;
          end else begin
            state_d = RESP;
            err_d   = (sel_op != OP_NO_OP);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.alu_done) begin
          result_d = bus.alu_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Everything below except req_ready is decoded from flops only.
  assign bus.req_ready  = (state_q == IDLE) ? gnt : '0;
  assign bus.alu_start  = (state_q == BUSY);
  assign bus.alu_op     = (state_q == BUSY) ? op_q : '0;
  assign bus.alu_a      = (state_q == BUSY) ? a_q : '0;
  assign bus.alu_b      = (state_q == BUSY) ? b_q : '0;
  assign bus.rsp_valid  = (state_q == RESP) ? (N_REQ'(1) << gidx_q) : '0;
  assign bus.rsp_result = (state_q == RESP) ? result_q : '0;
  assign bus.rsp_error  = (state_q == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: behavioural ALU (1-cycle ops, 3-cycle mul, optional hang),
// response scoreboard and per-feature scenario tasks.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  typedef struct { int idx; logic [15:0] result; logic err; } exp_t;
  typedef struct { logic [N-1:0] vec; logic [15:0] result; logic err; int cyc; } obs_t;
  typedef struct { int idx; int cyc; } acc_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.N_REQ(N)) bus ();

  alu_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t exp_q[$];
  obs_t obs_q[$];
  acc_t acc_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start_total = 0;
  int   run_len = 0;
  int   last_run = 0;
  int   bad_cnt = 0;
  int   ready_cnt[N] = '{default: 0};
  int   alu_cnt = 0;
  bit   hang = 1'b0;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: done one cycle after start for simple ops, three cycles for mul.
  always @(posedge clk) begin
    bus.alu_done <= 1'b0;
    if (!reset_n && cyc < 2) begin
      bus.alu_result <= '0;
      alu_cnt        <= 0;
    end else if (!bus.alu_start) begin
      alu_cnt <= 0;
    end else if (!bus.alu_done) begin
      alu_cnt <= alu_cnt + 1;
      if (!hang && (alu_cnt + 1 == ((bus.alu_op == 3'b100) ? 3 : 1))) begin
        bus.alu_done   <= 1'b1;
        bus.alu_result <= ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) acc_q.push_back('{idx: i, cyc: cyc});
        if (bus.req_ready[i]) ready_cnt[i] <= ready_cnt[i] + 1;
      end
      if ($countones(bus.req_ready) > 1) bad_cnt <= bad_cnt + 1;
    end
    if ($countones(bus.rsp_valid) > 1) bad_cnt <= bad_cnt + 1;
    if (bus.rsp_valid != '0)
      obs_q.push_back('{vec: bus.rsp_valid, result: bus.rsp_result, err: bus.rsp_error, cyc: cyc});
    if (bus.alu_start) begin
      start_total <= start_total + 1;
      run_len     <= run_len + 1;
    end else if (run_len > 0) begin
      last_run <= run_len;
      run_len  <= 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic v);
    bus.req_op[3*i +: 3] = op;
    bus.req_a[8*i +: 8]  = a;
    bus.req_b[8*i +: 8]  = b;
    bus.req_valid[i]     = v;
  endtask

  task automatic wait_acc(output int idx, output int t);
    acc_t e;
    idx = -1;
    t   = -1;
    for (int n = 0; n < 64; n++) begin
      step(1);
      if (acc_q.size() > 0) begin
        e   = acc_q.pop_front();
        idx = e.idx;
        t   = e.cyc;
        if (idx >= 0 && idx < N) bus.req_valid[idx] = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_rsp(output obs_t o, output bit ok);
    ok = 1'b0;
    o  = '{vec: '0, result: '0, err: 1'b0, cyc: -1};
    for (int n = 0; n < 64; n++) begin
      step(1);
      if (obs_q.size() > 0) begin
        o  = obs_q.pop_front();
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(3);
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== '0) begin
      failures++;
      $display("FAIL reset_handshake: ready=%b rsp_valid=%b, want 0/0", bus.req_ready, bus.rsp_valid);
    end
    checks++;
    if (bus.alu_start !== 1'b0 || {bus.alu_op, bus.alu_a, bus.alu_b} !== '0) begin
      failures++;
      $display("FAIL reset_alu: start=%b op=%h a=%h b=%h, want all 0", bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b);
    end
    checks++;
    if (bus.rsp_result !== 16'h0 || bus.rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp: result=%h err=%b, want 0000/0", bus.rsp_result, bus.rsp_error);
    end
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_add();
    int idx, t, r0;
    obs_t o; bit ok; exp_t e;
    r0 = ready_cnt[0];
    set_req(0, 3'b001, 8'h12, 8'h34, 1'b1);
    exp_q.push_back('{idx: 0, result: 16'h0046, err: 1'b0});
    wait_acc(idx, t);
    checks++;
    if (idx != 0) begin failures++; $display("FAIL add_grant: got %0d, want 0", idx); end
    wait_rsp(o, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o.vec !== onehot(e.idx) || o.result !== e.result || o.err !== e.err) begin
      failures++;
      $display("FAIL add_rsp: vec=%b res=%h err=%b, want vec=%b res=%h err=%b", o.vec, o.result, o.err, onehot(e.idx), e.result, e.err);
    end
    checks++;
    if (o.cyc != t + 3) begin failures++; $display("FAIL add_latency: rsp cycle %0d, want %0d", o.cyc, t + 3); end
    checks++;
    if (last_run != 2) begin failures++; $display("FAIL add_start_len: %0d cycles, want 2", last_run); end
    checks++;
    if (ready_cnt[0] - r0 != 1) begin failures++; $display("FAIL add_ready_len: %0d cycles, want 1", ready_cnt[0] - r0); end
  endtask

  task automatic test_mul();
    int idx, t;
    obs_t o; bit ok; exp_t e;
    set_req(1, 3'b100, 8'hFF, 8'hFF, 1'b1);
    exp_q.push_back('{idx: 1, result: 16'hFE01, err: 1'b0});
    wait_acc(idx, t);
    checks++;
    if (idx != 1) begin failures++; $display("FAIL mul_grant: got %0d, want 1", idx); end
    wait_rsp(o, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o.vec !== onehot(e.idx) || o.result !== e.result || o.err !== e.err) begin
      failures++;
      $display("FAIL mul_rsp: vec=%b res=%h err=%b, want vec=%b res=%h err=%b", o.vec, o.result, o.err, onehot(e.idx), e.result, e.err);
    end
    checks++;
    if (o.cyc != t + 5) begin failures++; $display("FAIL mul_latency: rsp cycle %0d, want %0d", o.cyc, t + 5); end
    // start high from T+1 through the done cycle T+4
    checks++;
    if (last_run != 4) begin failures++; $display("FAIL mul_start_len: %0d cycles, want 4", last_run); end
  endtask

  task automatic test_round_robin();
    int ord[6] = '{0, 1, 2, 3, 0, 2};
    logic [2:0] ops[4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    int idx, t;
    obs_t o; bit ok; exp_t e;
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    for (int i = 0; i < N; i++) begin
      set_req(i, ops[i], 8'(8'h30 + i), 8'h0F, 1'b1);
      exp_q.push_back('{idx: i, result: ref_alu(ops[i], 8'(8'h30 + i), 8'h0F), err: 1'b0});
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        set_req(0, 3'b001, 8'h80, 8'h80, 1'b1);
        set_req(2, 3'b100, 8'h10, 8'h11, 1'b1);
        exp_q.push_back('{idx: 0, result: 16'h0100, err: 1'b0});
        exp_q.push_back('{idx: 2, result: 16'h0110, err: 1'b0});
      end
      wait_acc(idx, t);
      checks++;
      if (idx != ord[k]) begin failures++; $display("FAIL rr_grant%0d: got %0d, want %0d", k, idx, ord[k]); end
      wait_rsp(o, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o.vec !== onehot(e.idx) || o.result !== e.result || o.err !== e.err) begin
        failures++;
        $display("FAIL rr_rsp%0d: vec=%b res=%h err=%b, want vec=%b res=%h err=%b", k, o.vec, o.result, o.err, onehot(e.idx), e.result, e.err);
      end
    end
  endtask

  task automatic test_local_ops();
    logic [2:0] ops[3] = '{3'b000, 3'b101, 3'b110};
    logic       errs[3] = '{1'b0, 1'b1, 1'b1};
    int idx, t, s0;
    obs_t o; bit ok; exp_t e;
    s0 = start_total;
    for (int k = 0; k < 3; k++) begin
      set_req(2, ops[k], 8'hAA, 8'h55, 1'b1);
      exp_q.push_back('{idx: 2, result: 16'h0000, err: errs[k]});
      wait_acc(idx, t);
      wait_rsp(o, ok);
      e = exp_q.pop_front();
      checks++;
      if (idx != 2 || !ok || o.vec !== onehot(e.idx) || o.result !== e.result || o.err !== e.err) begin
        failures++;
        $display("FAIL local_rsp op=%b: grant=%0d vec=%b res=%h err=%b, want grant=2 vec=%b res=%h err=%b", ops[k], idx, o.vec, o.result, o.err, onehot(e.idx), e.result, e.err);
      end
      checks++;
      if (o.cyc != t + 1) begin failures++; $display("FAIL local_latency op=%b: rsp cycle %0d, want %0d", ops[k], o.cyc, t + 1); end
    end
    checks++;
    if (start_total != s0) begin failures++; $display("FAIL local_no_start: %0d start cycles, want 0", start_total - s0); end
  endtask

  task automatic test_timeout();
    int idx, t, t2;
    obs_t o; bit ok; exp_t e;
    hang = 1'b1;
    set_req(3, 3'b001, 8'h01, 8'h02, 1'b1);
    exp_q.push_back('{idx: 3, result: 16'h0000, err: 1'b1});
    wait_acc(idx, t);
    set_req(1, 3'b011, 8'h0F, 8'hF0, 1'b1);
    exp_q.push_back('{idx: 1, result: 16'h00FF, err: 1'b0});
    wait_rsp(o, ok);
    hang = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (idx != 3 || !ok || o.vec !== onehot(e.idx) || o.result !== e.result || o.err !== e.err) begin
      failures++;
      $display("FAIL timeout_rsp: grant=%0d vec=%b res=%h err=%b, want grant=3 vec=%b res=%h err=%b", idx, o.vec, o.result, o.err, onehot(e.idx), e.result, e.err);
    end
    checks++;
    if (o.cyc != t + TO + 1) begin failures++; $display("FAIL timeout_latency: rsp cycle %0d, want %0d", o.cyc, t + TO + 1); end
    checks++;
    if (last_run != TO) begin failures++; $display("FAIL timeout_start_len: %0d cycles, want %0d", last_run, TO); end
    wait_acc(idx, t2);
    checks++;
    if (idx != 1 || t2 != t + TO + 2) begin failures++; $display("FAIL timeout_next_grant: idx=%0d cycle=%0d, want idx=1 cycle=%0d", idx, t2, t + TO + 2); end
    wait_rsp(o, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o.vec !== onehot(e.idx) || o.result !== e.result || o.err !== e.err) begin
      failures++;
      $display("FAIL timeout_next_rsp: vec=%b res=%h err=%b, want vec=%b res=%h err=%b", o.vec, o.result, o.err, onehot(e.idx), e.result, e.err);
    end
  endtask

  task automatic test_reset_mid_busy();
    int idx, t;
    obs_t o; bit ok; exp_t e;
    set_req(0, 3'b100, 8'h07, 8'h09, 1'b1);
    wait_acc(idx, t);
    step(1);
    checks++;
    if (bus.alu_start !== 1'b1) begin failures++; $display("FAIL midrst_busy: start=%b, want 1", bus.alu_start); end
    reset_n = 1'b0;
    step(1);
    checks++;
    if (bus.alu_start !== 1'b0 || {bus.alu_op, bus.alu_a, bus.alu_b} !== '0 || bus.rsp_valid !== '0 || bus.req_ready !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: start=%b op=%h a=%h b=%h rsp=%b ready=%b, want all 0", bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.req_ready);
    end
    step(2);
    reset_n = 1'b1;
    step(6);
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL midrst_no_rsp: %0d responses, want 0", obs_q.size()); end
    // after reset the pointer is back at 0, so req0 wins over req1
    set_req(0, 3'b001, 8'h21, 8'h43, 1'b1);
    set_req(1, 3'b001, 8'hF0, 8'h20, 1'b1);
    exp_q.push_back('{idx: 0, result: 16'h0064, err: 1'b0});
    exp_q.push_back('{idx: 1, result: 16'h0110, err: 1'b0});
    for (int k = 0; k < 2; k++) begin
      wait_acc(idx, t);
      checks++;
      if (idx != k) begin failures++; $display("FAIL midrst_grant%0d: got %0d, want %0d", k, idx, k); end
      wait_rsp(o, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o.vec !== onehot(e.idx) || o.result !== e.result || o.err !== e.err) begin
        failures++;
        $display("FAIL midrst_rsp%0d: vec=%b res=%h err=%b, want vec=%b res=%h err=%b", k, o.vec, o.result, o.err, onehot(e.idx), e.result, e.err);
      end
    end
  endtask

  task automatic test_end();
    step(4);
    checks++;
    if (bad_cnt != 0) begin failures++; $display("FAIL onehot: %0d multi-bit ready/rsp cycles, want 0", bad_cnt); end
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0 || acc_q.size() != 0) begin
      failures++;
      $display("FAIL leftovers: obs=%0d exp=%0d acc=%0d, want 0/0/0", obs_q.size(), exp_q.size(), acc_q.size());
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    test_reset();
    test_add();
    test_mul();
    test_round_robin();
    test_local_ops();
    test_timeout();
    test_reset_mid_busy();
    test_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
